// File: rtl/dma_cfg_pkg.sv
// dma_cfg_pkg: register offsets and one-hot FSM state encodings for dma_cfg_seq
package dma_cfg_pkg;
  localparam logic [9:0] OFF_MM2S_CR  = 10'h000;
  localparam logic [9:0] OFF_MM2S_SA  = 10'h018;
  localparam logic [9:0] OFF_MM2S_LEN = 10'h028;
  localparam logic [9:0] OFF_S2MM_CR  = 10'h030;
  localparam logic [9:0] OFF_S2MM_DA  = 10'h048;
  localparam logic [9:0] OFF_S2MM_LEN = 10'h058;
  typedef enum logic [4:0] {
    S_IDLE     = 5'b00001,
    S_ISSUE    = 5'b00010,
    S_WAIT_END = 5'b00100,
    S_NEXT     = 5'b01000,
    S_FIN      = 5'b10000
  } state_t;
  function automatic logic [9:0] reg_off(input logic [2:0] idx);
    return idx == 3'd0 ? OFF_MM2S_CR  :
           idx == 3'd1 ? OFF_MM2S_SA  :
           idx == 3'd2 ? OFF_MM2S_LEN :
           idx == 3'd3 ? OFF_S2MM_CR  :
           idx == 3'd4 ? OFF_S2MM_DA  : OFF_S2MM_LEN;
  endfunction
endpackage

// File: rtl/cfg_timeout_cnt.sv
// cfg_timeout_cnt: saturating wait counter; expired once it reaches LIMIT-1
module cfg_timeout_cnt #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int W = LIMIT > 1 ? $clog2(LIMIT) : 1;
  logic [W-1:0] r_cnt;
  assign o_expired = r_cnt == W'(LIMIT - 1);
  always_ff @(posedge clk)
    if (rst || i_clr) r_cnt <= '0;
    else if (i_en && !o_expired) r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/dma_cfg_seq.sv
// dma_cfg_seq: programs DMA channel registers through a single-outstanding lite writer.
// Define DMA_CFG_SEQ_S2MM_EN to append the three S2MM channel writes.
module dma_cfg_seq
  import dma_cfg_pkg::*;
#(
  parameter logic [31:0] CR_VALUE       = 32'h0000_1001,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] mm2s_addr,
  input  logic [31:0] mm2s_len,
  input  logic [31:0] s2mm_addr,
  input  logic [31:0] s2mm_len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [9:0]  lite_awaddr,
  output logic [31:0] lite_wdata,
  output logic        lite_valid,
  input  logic        lite_end
);
`ifdef DMA_CFG_SEQ_S2MM_EN
  localparam logic [2:0] LAST = 3'd5;
`else
  localparam logic [2:0] LAST = 3'd2;
`endif
  state_t      r_state, w_next;
  logic [2:0]  r_idx, w_idx_n;
  logic [31:0] r_ma, r_ml, w_data_n;
  logic [9:0]  r_awaddr;
  logic [31:0] r_wdata;
  logic        r_err, w_len0, w_expired;
`ifdef DMA_CFG_SEQ_S2MM_EN
  logic [31:0] r_sa, r_sl;
  assign w_len0 = mm2s_len == '0 || s2mm_len == '0;
`else
  logic w_unused;
  assign w_unused = ^{s2mm_addr, s2mm_len};
  assign w_len0 = mm2s_len == '0;
`endif
  // Entry from IDLE always loads write 0 (control register), so operands come from latched copies only.
  assign w_idx_n  = r_state == S_IDLE ? 3'd0 : r_idx + 3'd1;
  assign w_data_n = w_idx_n == 3'd1 ? r_ma :
                    w_idx_n == 3'd2 ? r_ml :
`ifdef DMA_CFG_SEQ_S2MM_EN
                    w_idx_n == 3'd4 ? r_sa :
                    w_idx_n == 3'd5 ? r_sl :
`endif
                    CR_VALUE;
  cfg_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (r_state == S_ISSUE),
    .i_en      (r_state == S_WAIT_END),
    .o_expired (w_expired)
  );
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     w_next = !start ? S_IDLE : w_len0 ? S_FIN : S_ISSUE;
      S_ISSUE:    w_next = S_WAIT_END;
      S_WAIT_END: w_next = lite_end ? S_NEXT : w_expired ? S_FIN : S_WAIT_END;
      S_NEXT:     w_next = r_idx == LAST ? S_FIN : S_ISSUE;
      S_FIN:      w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_err    <= 1'b0;
      r_ma     <= '0;
      r_ml     <= '0;
`ifdef DMA_CFG_SEQ_S2MM_EN
      r_sa     <= '0;
      r_sl     <= '0;
`endif
      r_awaddr <= '0;
      r_wdata  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) r_idx <= '0;
      if (r_state == S_NEXT) r_idx <= r_idx + 3'd1;
      if (r_state == S_IDLE && start) begin
        r_ma  <= mm2s_addr;
        r_ml  <= mm2s_len;
`ifdef DMA_CFG_SEQ_S2MM_EN
        r_sa  <= s2mm_addr;
        r_sl  <= s2mm_len;
`endif
        r_err <= w_len0;
      end
      if (r_state == S_WAIT_END && !lite_end && w_expired) r_err <= 1'b1;
      if (w_next == S_ISSUE) begin
        r_awaddr <= reg_off(w_idx_n);
        r_wdata  <= w_data_n;
      end
    end
  assign lite_valid  = r_state == S_ISSUE;
  assign done        = r_state == S_FIN;
  assign busy        = !(r_state == S_IDLE || r_state == S_FIN);
  assign err         = r_err;
  assign lite_awaddr = r_awaddr;
  assign lite_wdata  = r_wdata;
endmodule

// File: tb/tb_dma_cfg_seq.sv
// tb_dma_cfg_seq: randomized scoreboard bench for dma_cfg_seq with a list-based reference model
module tb_dma_cfg_seq;
  localparam int          TMO   = 16;
  localparam int          NEVER = 0;
  localparam logic [31:0] CR    = 32'h0000_1001;
`ifdef DMA_CFG_SEQ_S2MM_EN
  localparam bit S2MM = 1'b1;
`else
  localparam bit S2MM = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, end_wr = 1'b0, end_spur = 1'b0;
  logic [31:0] mm2s_addr = '0, mm2s_len = '0, s2mm_addr = '0, s2mm_len = '0;
  logic        busy, done, err, lite_valid, lite_end;
  logic [9:0]  lite_awaddr;
  logic [31:0] lite_wdata;
  assign lite_end = end_wr | end_spur;
  dma_cfg_seq #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mm2s_addr(mm2s_addr), .mm2s_len(mm2s_len),
    .s2mm_addr(s2mm_addr), .s2mm_len(s2mm_len),
    .busy(busy), .done(done), .err(err),
    .lite_awaddr(lite_awaddr), .lite_wdata(lite_wdata),
    .lite_valid(lite_valid), .lite_end(lite_end)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [9:0] a; logic [31:0] d;} wr_t;
  typedef struct packed {logic e; logic [1:0] kind;} dn_t;
  wr_t wq[$];
  dn_t dq[$];
  int  lat_q[$];
  int  n_chk = 0, n_fail = 0, cyc = 0;
  int  n_started = 0, n_done = 0, n_aborted = 0, start_cyc = 0, valid_cyc = 0;
  wr_t cur;
  dn_t mon_dn;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Reference: build the write list, stop after the first write whose reply never comes in time.
  task automatic push_model(input logic [31:0] ma, ml, sa, sl, input int lats[6]);
    wr_t wl[$];
    dn_t dn;
    wl.push_back(wr_t'{a: 10'h000, d: CR});
    wl.push_back(wr_t'{a: 10'h018, d: ma});
    wl.push_back(wr_t'{a: 10'h028, d: ml});
    if (S2MM) begin
      wl.push_back(wr_t'{a: 10'h030, d: CR});
      wl.push_back(wr_t'{a: 10'h048, d: sa});
      wl.push_back(wr_t'{a: 10'h058, d: sl});
    end
    dn = dn_t'{e: 1'b0, kind: 2'd0};
    if (ml == 0 || (S2MM && sl == 0)) dn = dn_t'{e: 1'b1, kind: 2'd2};
    else for (int i = 0; i < wl.size() && !dn.e; i++) begin
      wq.push_back(wl[i]);
      lat_q.push_back(lats[i]);
      if (lats[i] == NEVER || lats[i] > TMO) dn = dn_t'{e: 1'b1, kind: 2'd1};
    end
    dq.push_back(dn);
  endtask
  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    wq.delete(); dq.delete(); lat_q.delete();
    n_aborted = n_started - n_done;
  endtask
  task automatic wait_idle();
    int k = 0;
    while (n_started != n_done + n_aborted && k < 400) begin
      @(posedge clk);
      k++;
    end
    chk("sequence finished within bound", 64'(n_started != n_done + n_aborted), 0);
    if (n_started != n_done + n_aborted) do_reset();
    repeat (25) @(posedge clk);
  endtask
  task automatic txn(input logic [31:0] ma, ml, sa, sl, input int lats[6], input bit dbl);
    bit len0;
    len0 = ml == 0 || (S2MM && sl == 0);
    wait_idle();
    push_model(ma, ml, sa, sl, lats);
    @(posedge clk); #1;
    mm2s_addr = ma; mm2s_len = ml; s2mm_addr = sa; s2mm_len = sl;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    n_started++;
    mm2s_addr = $urandom; mm2s_len = $urandom; s2mm_addr = $urandom; s2mm_len = $urandom;
    if (dbl && !len0) begin
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
  endtask
  always @(negedge clk) if (!rst) begin
    chk("busy", 64'(busy), 64'((n_started != n_done + n_aborted) && !done));
    if (lite_valid) begin
      if (wq.size() == 0) chk("unexpected lite_valid", 64'(lite_valid), 0);
      else begin
        cur = wq.pop_front();
        chk("lite_awaddr", 64'(lite_awaddr), 64'(cur.a));
        chk("lite_wdata", 64'(lite_wdata), 64'(cur.d));
        valid_cyc = cyc;
      end
    end
    if (end_wr && busy) begin
      chk("lite_awaddr held to lite_end", 64'(lite_awaddr), 64'(cur.a));
      chk("lite_wdata held to lite_end", 64'(lite_wdata), 64'(cur.d));
    end
    if (done) begin
      if (dq.size() == 0) chk("unexpected done", 64'(done), 0);
      else begin
        mon_dn = dq.pop_front();
        chk("err at done", 64'(err), 64'(mon_dn.e));
        if (mon_dn.kind == 2'd1) chk("timeout done 16-17 cycles after lite_valid", 64'(cyc - valid_cyc >= 16 && cyc - valid_cyc <= 17), 1);
        if (mon_dn.kind == 2'd2) chk("zero-length done within 3 cycles", 64'(cyc - start_cyc <= 3), 1);
        n_done++;
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (lite_valid && !rst) begin
      int l;
      l = lat_q.size() > 0 ? lat_q.pop_front() : NEVER;
      if (l != NEVER) begin
        repeat (l) @(posedge clk);
        #1 end_wr = 1'b1;
        @(posedge clk);
        #1 end_wr = 1'b0;
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, %0d checks, %0d failures", n_chk, n_fail);
    $fatal(1);
  end
  initial begin
    int lats[6];
    int k;
    logic [31:0] ma, ml, sa, sl;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 64'(busy), 0);
    chk("reset done", 64'(done), 0);
    chk("reset err", 64'(err), 0);
    chk("reset lite_valid", 64'(lite_valid), 0);
    chk("reset lite_awaddr", 64'(lite_awaddr), 0);
    chk("reset lite_wdata", 64'(lite_wdata), 0);
    @(posedge clk); #1 rst = 1'b0;
    lats = '{8, 8, 8, 8, 8, 8};
    txn(32'h1000_0000, 32'h400, 32'h2000_0000, 32'h800, lats, 1'b0);
    lats = '{NEVER, NEVER, NEVER, NEVER, NEVER, NEVER};
    txn(32'h1000_0000, 32'h400, 32'h2000_0000, 32'h800, lats, 1'b0);
    lats = '{8, 8, 8, 8, 8, 8};
    txn(32'h1234_5678, 32'h0, 32'h2000_0000, 32'h800, lats, 1'b0);
    txn(32'hCAFE_0000, 32'h40, 32'hBEEF_0000, 32'h80, lats, 1'b0);
    wait_idle();
    @(posedge clk); #1 end_spur = 1'b1;
    @(posedge clk); #1 end_spur = 1'b0;
    lats = '{3, 5, 2, 4, 1, 6};
    txn(32'h0A0B_0C0D, 32'h100, 32'h0E0F_0000, 32'h200, lats, 1'b1);
    lats = '{8, 8, 8, 8, 8, 8};
    txn(32'h5555_0000, 32'h10, 32'h6666_0000, 32'h20, lats, 1'b0);
    k = 0;
    while (wq.size() > (S2MM ? 4 : 1) && k < 200) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    do_reset();
    @(negedge clk);
    chk("abort busy", 64'(busy), 0);
    chk("abort done", 64'(done), 0);
    chk("abort lite_valid", 64'(lite_valid), 0);
    chk("abort lite_awaddr", 64'(lite_awaddr), 0);
    chk("abort lite_wdata", 64'(lite_wdata), 0);
    lats = '{2, 2, 2, 2, 2, 2};
    txn(32'h7777_0000, 32'h30, 32'h8888_0000, 32'h60, lats, 1'b0);
    for (int t = 0; t < 30; t++) begin
      ma = $urandom;
      sa = $urandom;
      ml = $urandom_range(0, 5) == 0 ? 32'h0 : 32'($urandom_range(1, 32'hFFFF));
      sl = $urandom_range(0, 7) == 0 ? 32'h0 : 32'($urandom_range(1, 32'hFFFF));
      for (int i = 0; i < 6; i++)
        lats[i] = $urandom_range(0, 9) == 0 ? ($urandom_range(0, 1) == 0 ? NEVER : $urandom_range(17, 20))
                                            : $urandom_range(1, 16);
      txn(ma, ml, sa, sl, lats, 1'($urandom_range(0, 1)));
    end
    wait_idle();
    chk("write queue drained", 64'(wq.size()), 0);
    chk("done queue drained", 64'(dq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dma_cfg_seq.md
DMA_CFG_SEQ -- requirements
Module: dma_cfg_seq

Interface
REQ-001 Parameter CR_VALUE, default 32'h0000_1001, SHALL set the value written to each channel control register (RS bit plus IOC interrupt enable).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the maximum number of cycles to wait for lite_end per register write.
REQ-003 Port clk, input, 1: the single clock. One clock domain; all logic on posedge clk.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: single-cycle request to program one transfer.
REQ-006 Port mm2s_addr, input, 32: MM2S source address, sampled on an accepted start.
REQ-007 Port mm2s_len, input, 32: MM2S byte length, sampled on an accepted start.
REQ-008 Port s2mm_addr, input, 32: S2MM destination address; used only when DMA_CFG_SEQ_S2MM_EN is defined.
REQ-009 Port s2mm_len, input, 32: S2MM byte length; used only when DMA_CFG_SEQ_S2MM_EN is defined.
REQ-010 Port busy, output, 1: high from the cycle after an accepted start until done.
REQ-011 Port done, output, 1: one-cycle completion pulse.
REQ-012 Port err, output, 1: sticky error flag; cleared by the next accepted start.
REQ-013 Port lite_awaddr, output, 10: register offset presented to the lite writer.
REQ-014 Port lite_wdata, output, 32: register data presented to the lite writer.
REQ-015 Port lite_valid, output, 1: one-cycle pulse that launches one lite write.
REQ-016 Port lite_end, input, 1: one-cycle pulse from the lite writer marking write completion.

Function
REQ-017 States SHALL be IDLE, ISSUE, WAIT_END, NEXT and FIN, one-hot encoded.
REQ-018 In IDLE, start SHALL latch mm2s_addr, mm2s_len, s2mm_addr and s2mm_len, clear err, reset the write index to 0 and go to ISSUE; start in any other state SHALL be ignored.
REQ-019 Write list, in order: {0x000, CR_VALUE}, {0x018, mm2s_addr}, {0x028, mm2s_len}; the LENGTH write is last per channel.
REQ-020 ISSUE SHALL drive lite_valid=1 for exactly one cycle, then go to WAIT_END.
REQ-021 lite_awaddr/lite_wdata SHALL be set on entry to ISSUE and held stable through WAIT_END; the writer passes them through combinationally.
REQ-022 WAIT_END: on lite_end, go to NEXT; NEXT increments the index, returns to ISSUE if writes remain, else FIN.
REQ-023 WAIT_END timeout: if lite_end is absent for TIMEOUT_CYCLES cycles (counter reaches TIMEOUT_CYCLES-1), set err, abandon remaining writes, go to FIN.
REQ-024 A latched mm2s_len==0 (or s2mm_len==0 when enabled) SHALL skip all writes: the FSM goes directly to FIN with err=1.
REQ-025 FIN SHALL pulse done for one cycle and return to IDLE; busy is low in FIN.
REQ-026 A lite_end arriving in any state other than WAIT_END SHALL be ignored.
REQ-027 The timeout counter SHALL clear on every entry to WAIT_END and saturate; no wrap-around.

Reset
REQ-028 rst SHALL force IDLE, index=0, counter=0, busy=0, done=0, err=0, lite_valid=0, lite_awaddr=0, lite_wdata=0, and clear all latched operands.
REQ-029 rst mid-sequence SHALL abort without done; the lite writer SHALL share the same rst.

Configuration
REQ-030 With DMA_CFG_SEQ_S2MM_EN defined, three more writes SHALL follow in order: {0x030, CR_VALUE}, {0x048, s2mm_addr}, {0x058, s2mm_len}, for 6 writes total.
REQ-031 Without DMA_CFG_SEQ_S2MM_EN, exactly 3 writes SHALL occur, and s2mm_addr/s2mm_len are unused.

Structure
REQ-032 Package dma_cfg_pkg SHALL hold the register offset constants (0x000, 0x018, 0x028, 0x030, 0x048, 0x058) and the state encodings.
REQ-033 The timeout counter SHALL be sub-module cfg_timeout_cnt (clear, enable, parameterised limit, expired output).

Verification
REQ-034 start with mm2s_addr=0x1000_0000, mm2s_len=0x400, writer model responding with lite_end 8 cycles after lite_valid -> writes 0x000/0x1001, 0x018/0x1000_0000, 0x028/0x400; one done pulse; err=0.
REQ-035 Same stimulus with DMA_CFG_SEQ_S2MM_EN, s2mm_addr=0x2000_0000, s2mm_len=0x800 -> six writes in order, ending 0x058/0x800; done once.
REQ-036 Writer never returns lite_end, TIMEOUT_CYCLES=16 -> err=1 and done 16-17 cycles after the first lite_valid; no further lite_valid.
REQ-037 start with mm2s_len=0 -> no lite_valid; done and err=1 within 3 cycles.
REQ-038 Second start while busy, plus a spurious lite_end in IDLE -> both ignored; the write sequence is unchanged.
REQ-039 rst asserted during the second write's WAIT_END -> all outputs 0 next cycle; no done; a new start then runs a clean sequence.
